// File: rtl/npx_frame_sequencer.sv
// Streams one frame (a single lit ball pixel over a background) into a NeoPixel
// controller's pixel registers, fires the send, and waits for the strand to latch.
module npx_frame_sequencer #(
  parameter int NUM_NPX = 17,
  parameter int PW      = $clog2(NUM_NPX)
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          update,
  input  logic [PW-1:0] ball_pos,
  input  logic [23:0]   ball_rgb,
  input  logic [23:0]   bg_rgb,
  input  logic          npx_ready,
  output logic          npx_load,
  output logic [PW-1:0] npx_pixel,
  output logic [7:0]    npx_red,
  output logic [7:0]    npx_green,
  output logic [7:0]    npx_blue,
  output logic          npx_go,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, LOAD, FIRE, WAIT_LOW, WAIT_DONE
  } state_t;

  localparam logic [PW-1:0] LAST = PW'(NUM_NPX - 1);

  state_t        state;
  logic [PW-1:0] cnt;
  logic          pending;
  logic [PW-1:0] snap_pos;
  logic [23:0]   snap_ball;
  logic [23:0]   snap_bg;
  logic [23:0]   pix_rgb;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= 1'b0;
      snap_pos   <= '0;
      snap_ball  <= '0;
      snap_bg    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Requests arriving mid-frame collapse into a single follow-up frame.
      if (state != IDLE && update) pending <= 1'b1;
      case (state)
        IDLE: if (update || pending) begin
          snap_pos  <= ball_pos;
          snap_ball <= ball_rgb;
          snap_bg   <= bg_rgb;
          pending   <= 1'b0;
          state     <= WAIT_RDY;
        end
        WAIT_RDY: if (npx_ready) begin
          cnt   <= '0;
          state <= LOAD;
        end
        LOAD: if (npx_ready) begin
          if (cnt == LAST) state <= FIRE;
          else             cnt   <= cnt + 1'b1;
        end
        FIRE:      state <= WAIT_LOW;
        WAIT_LOW:  if (!npx_ready) state <= WAIT_DONE;
        WAIT_DONE: if (npx_ready) begin
          frame_done <= 1'b1;
          state      <= IDLE;
        end
        default:   state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registers; a pixel stalled by npx_ready=0 simply
  // stays on the bus until the controller takes it.
  assign npx_load  = (state == LOAD);
  assign npx_go    = (state == FIRE);
  assign busy      = (state != IDLE);
  assign npx_pixel = npx_load ? cnt : '0;
  assign pix_rgb   = !npx_load ? 24'd0 : ((cnt == snap_pos) ? snap_ball : snap_bg);
  assign npx_red   = pix_rgb[23:16];
  assign npx_green = pix_rgb[15:8];
  assign npx_blue  = pix_rgb[7:0];

endmodule

// File: tb/tb_npx_frame_sequencer.sv
// Randomized bench for npx_frame_sequencer: a scripted controller drives npx_ready,
// accepted pixels are scoreboarded against the frame the ball/background rules imply.
module tb_npx_frame_sequencer;
  localparam int N  = 17;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          update = 1'b0;
  logic          npx_ready = 1'b0;
  logic [PW-1:0] ball_pos = '0;
  logic [23:0]   ball_rgb = '0;
  logic [23:0]   bg_rgb = '0;
  logic          npx_load, npx_go, busy, frame_done;
  logic [PW-1:0] npx_pixel;
  logic [7:0]    npx_red, npx_green, npx_blue;

  npx_frame_sequencer #(.NUM_NPX(N), .PW(PW)) dut (
    .CLOCK_50(clk), .reset(reset), .update(update), .ball_pos(ball_pos),
    .ball_rgb(ball_rgb), .bg_rgb(bg_rgb), .npx_ready(npx_ready),
    .npx_load(npx_load), .npx_pixel(npx_pixel), .npx_red(npx_red),
    .npx_green(npx_green), .npx_blue(npx_blue), .npx_go(npx_go),
    .busy(busy), .frame_done(frame_done)
  );

  always #10 clk = ~clk;

  int checks = 0, errors = 0, go_cnt = 0, done_cnt = 0;
  logic [28:0] acc[$];
  wire [44:0] all_out = {npx_load, npx_pixel, npx_red, npx_green, npx_blue, npx_go, busy, frame_done};

  // Accepted-stream monitor plus always-on output invariants.
  always @(negedge clk) begin
    if (!reset) begin
      if (npx_load && npx_ready) acc.push_back({npx_pixel, npx_red, npx_green, npx_blue});
      if (npx_go) go_cnt++;
      if (frame_done) done_cnt++;
      checks++;
      if ((npx_load && npx_go) || (!npx_load && {npx_pixel, npx_red, npx_green, npx_blue} !== '0)) begin
        errors++;
        $display("FAIL invariant: load=%0b go=%0b pixel=%0d rgb=%02h%02h%02h, required no load+go and zero bus outside LOAD",
                 npx_load, npx_go, npx_pixel, npx_red, npx_green, npx_blue);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic pulse_update();
    update = 1'b1; cyc(); update = 1'b0;
  endtask

  task automatic set_frame(input int pos, input logic [23:0] b, input logic [23:0] g);
    ball_pos = pos[4:0]; ball_rgb = b; bg_rgb = g;
  endtask

  // Reference: pixel i shows the ball colour only where i equals the ball position.
  task automatic check_frame(input int pos, input logic [23:0] b, input logic [23:0] g, input string nm);
    logic [28:0] exp;
    logic [4:0]  ip;
    checks++;
    if (acc.size() !== N) begin
      errors++;
      $display("FAIL %s count: got %0d accepted pixels, required %0d", nm, acc.size(), N);
    end
    for (int i = 0; i < N && i < acc.size(); i++) begin
      ip  = i[4:0];
      exp = {ip, (i == pos) ? b : g};
      checks++;
      if (acc[i] !== exp) begin
        errors++;
        $display("FAIL %s pixel %0d: got %h, required %h", nm, i, acc[i], exp);
      end
    end
    acc.delete();
  endtask

  // Plays the controller from WAIT_RDY until frame_done has been observed.
  task automatic drive_frame(input int stall_at, input int stall_len, input bit rnd,
                             input int hold, input int inj_pos, input string nm);
    int phase = 0, lowc = 0, st = stall_len, c = 0;
    bit last_stall = 0, fin = 0;
    logic [4:0] last_pix = '0;
    while (!fin && c < 4000) begin
      if (phase == 0) begin
        if (last_stall) begin
          checks++;
          if (!(npx_load === 1'b1 && npx_pixel === last_pix)) begin
            errors++;
            $display("FAIL %s reissue: load=%0b pixel=%0d, required load=1 pixel=%0d", nm, npx_load, npx_pixel, last_pix);
          end
        end
        if (inj_pos >= 0) begin
          update = (c == 3 || c == 5 || c == 7);
          if (c == 4) ball_pos = inj_pos[4:0];
        end
        if (npx_go === 1'b1) begin
          phase = 1; lowc = hold; npx_ready = 1'b0;
        end else if (npx_load === 1'b1 && int'(npx_pixel) == stall_at && st > 0) begin
          npx_ready = 1'b0; st--;
        end else begin
          npx_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        last_stall = (phase == 0) && npx_load && !npx_ready;
        last_pix   = npx_pixel;
      end else if (phase == 1) begin
        lowc--;
        if (lowc <= 0) begin npx_ready = 1'b1; phase = 2; end
      end else begin
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s frame_done: done=%0b busy=%0b, required done=1 busy=0", nm, frame_done, busy);
        end
        fin = 1;
      end
      if (!fin) begin cyc(); c++; end
    end
    update = 1'b0;
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout: phase %0d after %0d cycles, required frame completion", nm, phase, c);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; update = 1'b1; npx_ready = 1'b1;
    set_frame(3, 24'hABCDEF, 24'h123456);
    cyc(); cyc();
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset outputs: got %h, required 0", all_out);
    end
    reset = 1'b0; update = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0 || npx_load !== 1'b0) begin
      errors++; $display("FAIL reset idle: busy=%0b load=%0b, required 0 0", busy, npx_load);
    end
  endtask

  task automatic test_basic();
    int g0 = go_cnt, d0 = done_cnt;
    npx_ready = 1'b1; acc.delete();
    set_frame(3, 24'hFF0000, 24'h000010);
    pulse_update();
    drive_frame(-1, 0, 0, 1000, -1, "basic");
    cyc();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic busy_after: got %0b, required 0", busy); end
    check_frame(3, 24'hFF0000, 24'h000010, "basic");
    checks++;
    if (go_cnt - g0 !== 1 || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL basic strobes: go=%0d done=%0d, required 1 1", go_cnt - g0, done_cnt - d0);
    end
  endtask

  task automatic test_latency();
    npx_ready = 1'b1; acc.delete();
    set_frame(9, 24'h00FF00, 24'h010101);
    update = 1'b1; cyc(); update = 1'b0;
    checks++;
    if (busy !== 1'b1 || npx_load !== 1'b0) begin
      errors++; $display("FAIL latency t+1: busy=%0b load=%0b, required 1 0", busy, npx_load);
    end
    cyc();
    checks++;
    if (npx_load !== 1'b1 || npx_pixel !== 5'd0) begin
      errors++; $display("FAIL latency t+2: load=%0b pixel=%0d, required 1 0", npx_load, npx_pixel);
    end
    drive_frame(-1, 0, 0, 3, -1, "latency");
    cyc();
    check_frame(9, 24'h00FF00, 24'h010101, "latency");
  endtask

  task automatic test_edges();
    int ps[4] = '{17, 16, 0, 31};
    foreach (ps[k]) begin
      npx_ready = 1'b1; acc.delete();
      set_frame(ps[k], 24'h0000FF, 24'h202020);
      pulse_update();
      drive_frame(-1, 0, 0, 2, -1, "edge");
      cyc();
      check_frame(ps[k], 24'h0000FF, 24'h202020, "edge");
    end
  endtask

  task automatic test_random();
    int pos;
    logic [23:0] b, g;
    for (int k = 0; k < 6; k++) begin
      pos = $urandom_range(0, 31); b = 24'($urandom); g = 24'($urandom);
      npx_ready = 1'b1; acc.delete();
      set_frame(pos, b, g);
      pulse_update();
      drive_frame(-1, 0, 1, $urandom_range(2, 30), -1, "random");
      cyc();
      check_frame(pos, b, g, "random");
    end
  endtask

  task automatic test_stall();
    npx_ready = 1'b1; acc.delete();
    set_frame(8, 24'hC0FFEE, 24'h0A0B0C);
    pulse_update();
    drive_frame(7, 4, 0, 4, -1, "stall");
    cyc();
    check_frame(8, 24'hC0FFEE, 24'h0A0B0C, "stall");
  endtask

  task automatic test_coalesce();
    int d0 = done_cnt;
    bit stray = 0;
    npx_ready = 1'b1; acc.delete();
    set_frame(2, 24'h112233, 24'h445566);
    pulse_update();
    drive_frame(-1, 0, 0, 5, 5, "coal1");
    check_frame(2, 24'h112233, 24'h445566, "coal1");
    cyc();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL coal pending_restart: busy=%0b, required 1", busy); end
    drive_frame(-1, 0, 0, 5, -1, "coal2");
    check_frame(5, 24'h112233, 24'h445566, "coal2");
    for (int k = 0; k < 6; k++) begin cyc(); if (busy !== 1'b0) stray = 1; end
    checks++;
    if (stray || done_cnt - d0 !== 2) begin
      errors++; $display("FAIL coal extra_frames: stray_busy=%0b frames=%0d, required 0 2", stray, done_cnt - d0);
    end
  endtask

  task automatic test_reset_midframe();
    int d0, c = 0;
    bit bad = 0;
    npx_ready = 1'b1;
    set_frame(4, 24'h777777, 24'h000001);
    pulse_update();
    while (npx_go !== 1'b1 && c < 100) begin cyc(); c++; end
    checks++;
    if (npx_go !== 1'b1) begin errors++; $display("FAIL rstmid go: got %0b, required 1", npx_go); end
    cyc(); cyc(); cyc();
    reset = 1'b1; cyc();
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL rstmid outputs: got %h, required 0", all_out); end
    reset = 1'b0; npx_ready = 1'b0; d0 = done_cnt;
    repeat (50) cyc();
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid aborted: done=%0d busy=%0b, required 0 0", done_cnt - d0, busy);
    end
    acc.delete();
    set_frame(12, 24'h00AA00, 24'h050505);
    pulse_update();
    for (int k = 0; k < 10; k++) begin
      if (busy !== 1'b1 || npx_load !== 1'b0) bad = 1;
      cyc();
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rstmid wait_rdy: left WAIT_RDY with ready low, required hold"); end
    drive_frame(-1, 0, 0, 3, -1, "rstmid");
    cyc();
    check_frame(12, 24'h00AA00, 24'h050505, "rstmid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_edges();
    test_stall();
    test_random();
    test_coalesce();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
